// File: rtl/serial_word_loader.sv
// serial_word_loader
//   Serial-to-parallel front end for a generic n-bit register. Bits arrive
//   MSB first on sdata, qualified by the sbit strobe. Once a complete word
//   has been received, control pulses for one cycle so the downstream
//   register captures d. At every other time the register holds its value.
//
//   Optional feature: define SERIAL_WORD_LOADER_PARITY_EN to expect one
//   even-parity bit after the n data bits. A matching parity bit loads the
//   word. A mismatch pulses parErr and drops the frame. When the macro is
//   undefined, parErr is tied low.
//
// Ports
//   clk      in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   start    in   begin a frame (sampled only when idle)
//   abort    in   drop the current frame (SHIFT/PARITY only, beats sbit)
//   sbit     in   bit strobe, sdata valid when high
//   sdata    in   serial data, MSB first
//   d        out  assembled word -> register d
//   control  out  one-cycle load pulse -> register control
//   busy     out  high whenever not idle
//   parErr   out  one-cycle parity failure pulse
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start; d keeps the last word
// SHIFT  | shifting in data bits on each strobe
// PARITY | waiting for the even-parity bit (parity build only)
// LOAD   | control high for this one cycle, then back to IDLE

module serial_word_loader #(
    parameter int n = 16
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic         abort,
    input  logic         sbit,
    input  logic         sdata,
    output logic [n-1:0] d,
    output logic         control,
    output logic         busy,
    output logic         parErr
);

    localparam int CW = $clog2(n + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOAD   = 2'd3
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        ,
        ST_PARITY = 2'd2
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  d_q, d_d;
    logic [CW-1:0] cnt_q, cnt_d;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    logic          parerr_q, parerr_d;
`endif

    always_comb begin
        state_d = state_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        parerr_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Strobes are ignored here, even one coincident with start.
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sbit) begin
                    d_d   = {d_q[n-2:0], sdata};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_LOAD;
`endif
                    end
                end
            end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            ST_PARITY: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (sbit) begin
                    // Even parity: the parity bit equals the XOR of the data.
                    if (sdata == ^d_q) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d  = ST_IDLE;
                        parerr_d = 1'b1;
                    end
                end
            end
`endif
            ST_LOAD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            d_q      <= '0;
            cnt_q    <= '0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            parerr_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            d_q      <= d_d;
            cnt_q    <= cnt_d;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            parerr_q <= parerr_d;
`endif
        end
    end

    assign d       = d_q;
    assign control = (state_q == ST_LOAD);
    assign busy    = (state_q != ST_IDLE);
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    assign parErr  = parerr_q;
`else
    assign parErr  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
module tb_serial_word_loader;

    localparam int N = 8;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         sbit = 1'b0;
    logic         sdata = 1'b0;
    logic [N-1:0] d;
    logic         control;
    logic         busy;
    logic         parErr;

    int errors = 0;
    int checks = 0;
    int pulses = 0;

    serial_word_loader #(.n(N)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .abort   (abort),
        .sbit    (sbit),
        .sdata   (sdata),
        .d       (d),
        .control (control),
        .busy    (busy),
        .parErr  (parErr)
    );

    always #5 clk = ~clk;

    // Behavioural reference: tracks whether a frame is open, how many bits
    // of it have been collected, and which one-cycle pulse is due.
    bit         m_in_frame;
    bit [N-1:0] m_word;
    int         m_nbits;
    bit         m_load;
    bit         m_perr;

    function automatic void model_reset();
        m_in_frame = 1'b0;
        m_word     = '0;
        m_nbits    = 0;
        m_load     = 1'b0;
        m_perr     = 1'b0;
    endfunction

    function automatic void model_edge();
        bit nl = 1'b0;
        bit np = 1'b0;
        if (m_load) begin
            m_in_frame = 1'b0;
        end else if (!m_in_frame) begin
            if (start) begin
                m_in_frame = 1'b1;
                m_nbits    = 0;
            end
        end else if (abort) begin
            m_in_frame = 1'b0;
        end else if (sbit) begin
            if (m_nbits < N) begin
                m_word  = {m_word[N-2:0], sdata};
                m_nbits = m_nbits + 1;
                if (m_nbits == N && !PAR) nl = 1'b1;
            end else if (sdata == ^m_word) begin
                nl = 1'b1;
            end else begin
                m_in_frame = 1'b0;
                np = 1'b1;
            end
        end
        m_load = nl;
        m_perr = np;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_edge();
        #1;
        if (control === 1'b1) pulses++;
        check("model_d", d, m_word);
        check("model_control", control, m_load);
        check("model_busy", busy, m_in_frame || m_load);
        check("model_parErr", parErr, m_perr);
    endtask

    task automatic cyc(input bit st, input bit ab, input bit sb, input bit sd);
        start = st;
        abort = ab;
        sbit  = sb;
        sdata = sd;
        step();
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        bit         st;
        bit         sb;
        bit         sd;
        bit         e_ctl;
        bit         e_busy;
        logic [7:0] e_d;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] w;

        model_reset();
        #12;
        check("reset_d", d, 0);
        check("reset_busy", busy, 0);
        check("reset_control", control, 0);
        check("reset_parErr", parErr, 0);
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Frame 8'hA5 with sbit held high; strobe with start is ignored.
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h01});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h05});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0A});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h14});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h29});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h52});
        tbl.push_back('{1'b0, 1'b1, 1'b1, !PAR, 1'b1, 8'hA5});
        if (PAR) tbl.push_back('{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hA5});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5});
        foreach (tbl[i]) begin
            cyc(tbl[i].st, 1'b0, tbl[i].sb, tbl[i].sd);
            check($sformatf("tbl%0d_control", i), control, tbl[i].e_ctl);
            check($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
            check($sformatf("tbl%0d_d", i), d, tbl[i].e_d);
        end

        // Abort together with the 5th strobe.
        pulses = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        check("abort_busy", busy, 0);
        check("abort_control", control, 0);
        check("abort_d", d, 8'h5D);
        idle(3);
        check("abort_pulses", pulses, 0);

        // Gapped strobes with start pulses during the frame.
        pulses = 0;
        w = 8'h3C;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = N - 1; i >= 0; i--) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b1, w[i]);
        end
        if (PAR) cyc(1'b1, 1'b0, 1'b1, ^w);
        idle(3);
        check("gap_d", d, 8'h3C);
        check("gap_pulses", pulses, 1);

        // Reset after 5 bits, then a full 8'hFF frame.
        pulses = 0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        check("prereset_pulses", pulses, 0);
        resetn = 1'b0;
        #2;
        check("midreset_d", d, 0);
        check("midreset_busy", busy, 0);
        check("midreset_control", control, 0);
        idle(2);
        resetn = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        if (PAR) cyc(1'b0, 1'b0, 1'b1, 1'b0);
        check("ff_control", control, 1);
        idle(2);
        check("ff_d", d, 8'hFF);
        check("ff_pulses", pulses, 1);

        if (PAR) begin
            // A5 with a bad parity bit: parErr, no load, back to idle.
            pulses = 0;
            w = 8'hA5;
            cyc(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = N - 1; i >= 0; i--) cyc(1'b0, 1'b0, 1'b1, w[i]);
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            check("perr_pulse", parErr, 1);
            check("perr_control", control, 0);
            check("perr_busy", busy, 0);
            idle(1);
            check("perr_clear", parErr, 0);
            check("perr_pulses", pulses, 0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom % 6) == 0, ($urandom % 20) == 0,
                ($urandom % 3) != 0, $urandom % 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
